// File: rtl/mult_datapath.sv
// Register and arithmetic datapath of the 8-bit signed shift-add multiplier.
// Holds X, A and B and executes the controller's one-cycle strobes.
module mult_datapath #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Clr_Ld,
   input  logic             Clr_A,
   input  logic             Add,
   input  logic             Sub,
   input  logic             Shift,
   input  logic [WIDTH-1:0] S,
   output logic             X,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             M
);

   logic [WIDTH:0] a_ext;
   logic [WIDTH:0] s_ext;
   logic [WIDTH:0] s_opnd;
   logic [WIDTH:0] sum;

   // One WIDTH+1 bit adder serves both Add and Sub; Sub inverts S and injects
   // the +1 as carry-in. The carry out of the top bit falls off the result width.
   always_comb begin
      a_ext  = {A[WIDTH-1], A};
      s_ext  = {S[WIDTH-1], S};
      s_opnd = Sub ? ~s_ext : s_ext;
      sum    = a_ext + s_opnd + {{WIDTH{1'b0}}, Sub};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; the shift reads old X, A and B together.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         X <= 1'b0;
         A <= '0;
         B <= '0;
      end else if (Clr_Ld) begin
         X <= 1'b0;
         A <= '0;
         B <= S;
      end else if (Clr_A) begin
         X <= 1'b0;
         A <= '0;
      end else if (Add || Sub) begin
         {X, A} <= sum;
      end else if (Shift) begin
         A <= {X, A[WIDTH-1:1]};
         B <= {A[0], B[WIDTH-1:1]};
      end
   end

   assign M = B[0];

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: arithmetic reference model compared
// every cycle, directed literal cases, full multiplies and random strobes.
module tb_mult_datapath;

   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] LD   = 5'b10000;
   localparam logic [4:0] CA   = 5'b01000;
   localparam logic [4:0] AD   = 5'b00100;
   localparam logic [4:0] SB   = 5'b00010;
   localparam logic [4:0] SH   = 5'b00001;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Clr_Ld = 1'b0;
   logic       Clr_A = 1'b0;
   logic       Add = 1'b0;
   logic       Sub = 1'b0;
   logic       Shift = 1'b0;
   logic [7:0] S = 8'h00;
   logic       X;
   logic [7:0] A;
   logic [7:0] B;
   logic       M;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   mult_datapath #(.WIDTH(8)) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .Clr_Ld (Clr_Ld),
      .Clr_A  (Clr_A),
      .Add    (Add),
      .Sub    (Sub),
      .Shift  (Shift),
      .S      (S),
      .X      (X),
      .A      (A),
      .B      (B),
      .M      (M)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: {X,A} is a 9-bit signed number, {X,A,B} a 17-bit one.
   int m_x = 0;
   int m_a = 0;
   int m_b = 0;
   int acc;
   int v;

   function automatic int sx8(input int val);
      return (val >= 128) ? val - 256 : val;
   endfunction

   always @(posedge Clk) begin
      if (Reset) begin
         m_x = 0; m_a = 0; m_b = 0;
      end else if (Clr_Ld) begin
         m_x = 0; m_a = 0; m_b = int'(S);
      end else if (Clr_A) begin
         m_x = 0; m_a = 0;
      end else if (Add || Sub) begin
         acc = Sub ? sx8(m_a) - sx8(int'(S)) : sx8(m_a) + sx8(int'(S));
         acc = acc & 511;
         m_x = acc / 256;
         m_a = acc % 256;
      end else if (Shift) begin
         v   = m_x * 65536 + m_a * 256 + m_b;
         v   = v / 2 + m_x * 65536;
         m_a = (v / 256) % 256;
         m_b = v % 256;
      end
   end

   always @(negedge Clk) begin
      if (chk_en)
         check("model_cmp", {14'd0, X, A, B, M},
               {14'd0, m_x[0], m_a[7:0], m_b[7:0], m_b[0]});
   end

   task automatic step(input logic [4:0] stb, input logic [7:0] s, input logic rst);
      {Clr_Ld, Clr_A, Add, Sub, Shift} = stb;
      S     = s;
      Reset = rst;
      @(posedge Clk);
      #1;
      {Clr_Ld, Clr_A, Add, Sub, Shift} = NONE;
      Reset = 1'b0;
   endtask

   // Bench acts as the controller, deciding Add/Sub from M.
   task automatic run_mult(input logic [7:0] mcand, input logic [7:0] mplier, input string name);
      int p;
      logic [15:0] p16;
      step(LD, mplier, 1'b0);
      step(CA, mcand, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(M ? ((i == 7) ? SB : AD) : NONE, mcand, 1'b0);
         step(SH, mcand, 1'b0);
      end
      p   = $signed(mcand) * $signed(mplier);
      p16 = p[15:0];
      check({name, "_prod"}, {16'd0, A, B}, {16'd0, p16});
      check({name, "_sign"}, {31'd0, X}, {31'd0, (p < 0)});
   endtask

   logic [4:0] rstb;

   initial begin
      step(NONE, 8'h00, 1'b1);
      chk_en = 1'b1;

      // Reset with state X=1, A=0x55, B=0xAA and all strobes high.
      step(LD, 8'hAA, 1'b0);
      step(AD, 8'hAB, 1'b0);
      step(AD, 8'hAA, 1'b0);
      check("pre_reset", {15'd0, X, A, B}, {15'd0, 1'b1, 8'h55, 8'hAA});
      step(5'b11111, 8'hFF, 1'b1);
      check("reset", {14'd0, X, A, B, M}, 32'd0);

      // Clr_Ld over X=1, A=0x33.
      step(AD, 8'h99, 1'b0);
      step(AD, 8'h9A, 1'b0);
      check("pre_ld", {23'd0, X, A}, {23'd0, 1'b1, 8'h33});
      step(LD, 8'h5A, 1'b0);
      check("clr_ld", {14'd0, X, A, B, M}, {14'd0, 1'b0, 8'h00, 8'h5A, 1'b0});
      step(AD, 8'h11, 1'b0);
      step(CA | SH, 8'h00, 1'b0);
      check("clr_a_shift", {15'd0, X, A, B}, {15'd0, 1'b0, 8'h00, 8'h5A});

      // Single-step arithmetic.
      step(AD, 8'h7F, 1'b0);
      step(AD, 8'h01, 1'b0);
      check("add_7f_01", {23'd0, X, A}, {23'd0, 1'b0, 8'h80});
      step(SB, 8'h01, 1'b0);
      check("sub_80_01", {23'd0, X, A}, {23'd0, 1'b1, 8'h7F});
      step(CA, 8'h00, 1'b0);
      step(AD, 8'h10, 1'b0);
      step(AD | SB, 8'h03, 1'b0);
      check("add_sub_both", {23'd0, X, A}, {23'd0, 1'b0, 8'h0D});

      // Shift with X=1, A=0x81, B=0x02, then idle.
      step(LD, 8'h02, 1'b0);
      step(AD, 8'h81, 1'b0);
      step(SH, 8'h00, 1'b0);
      check("shift", {14'd0, X, A, B, M}, {14'd0, 1'b1, 8'hC0, 8'h81, 1'b1});
      for (int i = 0; i < 5; i++) step(NONE, 8'(i * 37), 1'b0);
      check("idle_hold", {14'd0, X, A, B, M}, {14'd0, 1'b1, 8'hC0, 8'h81, 1'b1});

      // Full multiplies with literal expectations.
      run_mult(8'h07, 8'hFD, "m7xm3");
      check("m7xm3_lit", {15'd0, X, A, B}, {15'd0, 1'b1, 8'hFF, 8'hEB});
      run_mult(8'h80, 8'h80, "m128x128");
      check("m128x128_lit", {15'd0, X, A, B}, {15'd0, 1'b0, 8'h40, 8'h00});
      run_mult(8'h80, 8'h7F, "m127x128");
      check("m127x128_lit", {15'd0, X, A, B}, {15'd0, 1'b1, 8'hC0, 8'h80});
      run_mult(8'h5A, 8'h00, "m0x5a");
      check("m0x5a_lit", {15'd0, X, A, B}, 32'd0);

      // Random multiplies.
      for (int i = 0; i < 20; i++)
         run_mult(8'($urandom), 8'($urandom), "rand_mult");

      // Random strobe soup, checked against the model every cycle.
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 5; k++) rstb[k] = ($urandom_range(3) == 0);
         step(rstb, 8'($urandom), ($urandom_range(31) == 0));
      end

      @(negedge Clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
